sevenseg_scan: RTL and testbench

//  Parametrised multi-digit 7-segment display driver for board score/status readout.

---
 rtl/sevenseg_scan.sv | 208 ++++++++++++++++++++
 tb/tb_sevenseg_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Multiplexed 7-segment driver: binary->BCD (one bit/clk) or raw hex. Display regs update DATA_W+2 clks after load (2 in hex).
// Loads arriving while busy are dropped; scan outputs are registered with 1 clk latency.
module sevenseg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  load,
    input  logic                  hex_mode,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    function automatic int calc_bcd_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                v = v / 10;
                n++;
            end
        end
        return n;
    endfunction

    localparam int BCD_DIGITS = calc_bcd_digits(DATA_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(DATA_W + 1);
    localparam int DIV_W      = $clog2(SCAN_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    state_t                         state_q, state_d;
    logic [DATA_W-1:0]              shift_q, shift_d;
    logic [BCD_W-1:0]               bcd_q, bcd_d;
    logic                           hex_q, hex_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           busy_q, busy_d;
    logic [NUM_DIGITS-1:0][3:0]     disp_q, disp_d;
    logic                           ovf_q, ovf_d;
    logic [DIV_W-1:0]               div_q, div_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [6:0]                     seg_q, seg_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;

    logic [BCD_W-1:0]               bcd_adj;
    logic [63:0]                    src;
    logic [NUM_DIGITS-1:0][3:0]     new_dig;
    logic                           new_ovf;
    logic [NUM_DIGITS-1:0]          blank;
    logic                           zero_hi;

    // Double-dabble correction step: nibbles >=5 get +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Hex mode keeps the raw value in shift_q; both paths reduce to nibble extraction.
    always_comb begin
        src     = hex_q ? 64'(shift_q) : 64'(bcd_q);
        new_dig = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            new_dig[k] = src[4*k +: 4];
        end
        new_ovf = |(src >> (4 * NUM_DIGITS));
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d = data_in;
                    hex_d   = hex_mode;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = hex_mode ? S_COMMIT : S_CONV;
                end
            end
            S_CONV: begin
                bcd_d   = BCD_W'({bcd_adj, shift_q[DATA_W-1]});
                shift_d = shift_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d  = new_dig;
                ovf_d   = new_ovf;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CONV);
    end

    // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        blank   = '0;
        zero_hi = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_hi  = zero_hi & (disp_q[k] == 4'd0);
            blank[k] = zero_hi && (k > 0);
        end
    end

    always_comb begin
        div_d = (div_q == DIV_W'(SCAN_DIV - 1)) ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        if (ovf_q) begin
            seg_d = 7'h3F;
        end else if ((BLANK_LZ != 0) && blank[idx_q]) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = glyph(disp_q[idx_q]);
        end
        an_d        = '1;
        an_d[idx_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            hex_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign seg_n    = seg_q;
    assign an_n     = an_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with a short scan period; expected glyphs are hand-computed.
module tb_sevenseg_scan;

    localparam int ND = 4;
    localparam int DW = 14;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in;
    logic          load;
    logic          hex_mode;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] got_seg [ND];

    sevenseg_scan #(
        .NUM_DIGITS(ND),
        .DATA_W    (DW),
        .SCAN_DIV  (SD),
        .BLANK_LZ  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .load     (load),
        .hex_mode (hex_mode),
        .busy     (busy),
        .overflow (overflow),
        .seg_n    (seg_n),
        .an_n     (an_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_digits();
        logic [ND-1:0] sel;
        for (int k = 0; k < ND; k++) got_seg[k] = 7'h55;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2 * ND * SD + 2; i++) begin
            @(negedge clk);
            for (int k = 0; k < ND; k++) begin
                sel    = '1;
                sel[k] = 1'b0;
                if (an_n == sel) got_seg[k] = seg_n;
            end
        end
    endtask

    task automatic check_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0);
        read_digits();
        check({tag, "_d3"}, 32'(got_seg[3]), 32'(d3));
        check({tag, "_d2"}, 32'(got_seg[2]), 32'(d2));
        check({tag, "_d1"}, 32'(got_seg[1]), 32'(d1));
        check({tag, "_d0"}, 32'(got_seg[0]), 32'(d0));
    endtask

    task automatic do_load(input logic [DW-1:0] v, input logic hx);
        @(negedge clk);
        data_in  = v;
        hex_mode = hx;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int            cnt;
        int            lat;
        logic          hb;
        logic [ND-1:0] exp_an;
        int            di;

        load     = 1'b0;
        hex_mode = 1'b0;
        data_in  = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_seg",  32'(seg_n), 32'h7F);
        check("rst_an",   32'(an_n), 32'hF);

        // Scan sequence after release: each digit held for SD clocks, 1 clk behind the index.
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            di         = ((k - 1) / SD) % ND;
            exp_an     = '1;
            exp_an[di] = 1'b0;
            check("scan_an",  32'(an_n), 32'(exp_an));
            check("scan_seg", 32'(seg_n), (di == 0) ? 32'h40 : 32'h7F);
        end

        do_load(14'd1234, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(cnt), 32'd14);
        check_digits("dec1234", 7'h79, 7'h24, 7'h30, 7'h19);
        check("ovf_1234", 32'(overflow), 32'd0);

        // Overflow is a display register, so its rise times the load-to-commit latency.
        @(negedge clk);
        data_in  = 14'd10000;
        hex_mode = 1'b0;
        load     = 1'b1;
        lat      = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) load = 1'b0;
            if (overflow && lat == 0) lat = n;
        end
        check("ovf_latency", 32'(lat), 32'd16);
        check_digits("ovf10000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        wait_idle();
        do_load(14'd7, 1'b0);
        wait_idle();
        check_digits("dec7", 7'h7F, 7'h7F, 7'h7F, 7'h78);
        check("ovf_7", 32'(overflow), 32'd0);

        do_load(14'h2BEF, 1'b1);
        hb = busy;
        repeat (6) begin
            @(negedge clk);
            hb = hb | busy;
        end
        check("hex_busy", 32'(hb), 32'd0);
        check_digits("hex2BEF", 7'h24, 7'h03, 7'h06, 7'h0E);

        @(negedge clk);
        data_in  = 14'd42;
        hex_mode = 1'b0;
        load     = 1'b1;
        @(negedge clk);
        data_in  = 14'd99;
        check("busy_2nd_load", 32'(busy), 32'd1);
        @(negedge clk);
        load = 1'b0;
        wait_idle();
        check_digits("dec42", 7'h7F, 7'h7F, 7'h19, 7'h24);
        do_load(14'd99, 1'b0);
        wait_idle();
        check_digits("dec99", 7'h7F, 7'h7F, 7'h10, 7'h10);

        do_load(14'd5555, 1'b0);
        repeat (5) @(negedge clk);
        check("busy_pre_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_seg",  32'(seg_n), 32'h7F);
        check("abort_an",   32'(an_n), 32'hF);
        check("abort_ovf",  32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check_digits("post_abort", 7'h7F, 7'h7F, 7'h7F, 7'h40);
        check("post_abort_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
